// File: rtl/trinity_pkg.sv
// rtl/trinity_pkg.sv - shared trit encodings, scheduler state type and trit normaliser
package trinity_pkg;

  localparam logic [1:0] TRIT_Z = 2'b00;
  localparam logic [1:0] TRIT_P = 2'b01;
  localparam logic [1:0] TRIT_N = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_APPLY = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  // The unused code 11 is folded onto Z so it can never propagate.
  function automatic logic [1:0] trit_norm(input logic [1:0] t);
    return (t == 2'b11) ? TRIT_Z : t;
  endfunction

endpackage

// File: rtl/trinity_trit_sat_add.sv
// rtl/trinity_trit_sat_add.sv - combinational saturating ternary add of two trits
module trinity_trit_sat_add (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] y
);
  import trinity_pkg::*;

  logic [1:0] a_n;
  logic [1:0] b_n;

  always_comb begin
    a_n = trit_norm(a);
    b_n = trit_norm(b);
    y   = TRIT_Z;
    if (a_n == TRIT_Z)
      y = b_n;
    else if (b_n == TRIT_Z)
      y = a_n;
    else if (a_n == b_n)
      y = a_n;
    else
      y = TRIT_Z;
  end

endmodule

// File: rtl/trinity_mutation_scheduler.sv
// rtl/trinity_mutation_scheduler.sv - walks the weight memory once per generation applying sequencer mutations
module trinity_mutation_scheduler #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              seq_enable,
  input  logic [1:0]        mutation_trit,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [1:0]        mem_rdata,
  output logic              mem_we,
  output logic [1:0]        mem_wdata,
  output logic [ADDR_W:0]   mut_count,
  output logic [15:0]       gen_count
);
  import trinity_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  sched_state_t      state;
  sched_state_t      state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_m1;
  logic              last_addr;
  logic              aborted_q;
  logic              mut_nz;
  logic              walking;
  logic              write_en;
  logic [1:0]        sum;

  trinity_trit_sat_add u_sat_add (
    .a (mem_rdata),
    .b (mutation_trit),
    .y (sum)
  );

  assign len_m1    = len_q - LEN_ONE;
  assign last_addr = ({1'b0, addr} == len_m1);
  assign mut_nz    = (trit_norm(mutation_trit) != TRIT_Z);
  assign walking   = (state == ST_FETCH) || (state == ST_APPLY);
  // Abort in APPLY kills the write in the same cycle, so mem_we is combinational on abort.
  assign write_en  = (state == ST_APPLY) && !abort && mut_nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start)
          state_nx = (len == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: state_nx = abort ? ST_IDLE : ST_APPLY;
      ST_APPLY: begin
        if (abort)
          state_nx = ST_IDLE;
        else if (last_addr)
          state_nx = ST_DONE;
        else
          state_nx = ST_FETCH;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    aborted    = aborted_q;
    seq_enable = (state == ST_FETCH);
    mem_re     = (state == ST_FETCH);
    mem_addr   = walking ? addr : '0;
    mem_we     = write_en;
    mem_wdata  = write_en ? sum : TRIT_Z;
  end

  // The address counter only advances when another visit follows, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      len_q     <= '0;
      aborted_q <= 1'b0;
      mut_count <= '0;
      gen_count <= '0;
    end else begin
      aborted_q <= walking && abort;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q     <= len;
            addr      <= '0;
            mut_count <= '0;
          end
        end
        ST_APPLY: begin
          if (!abort) begin
            if (mut_nz)
              mut_count <= mut_count + LEN_ONE;
            if (!last_addr)
              addr <= addr + ADDR_ONE;
          end
        end
        ST_DONE: gen_count <= gen_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trinity_mutation_scheduler.sv
// tb/tb_trinity_mutation_scheduler.sv - directed self-checking bench for the mutation scheduler
module tb_trinity_mutation_scheduler;

  localparam int AW = 3;
  localparam logic [1:0] Z = 2'b00, P = 2'b01, N = 2'b10, X3 = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW:0]   len;
  logic          busy, done, aborted, seq_enable, mem_re, mem_we;
  logic [1:0]    mutation_trit, mem_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   mut_count;
  logic [15:0]   gen_count;

  logic [1:0] mem [8];
  logic [1:0] pre [8];
  logic [1:0] tr  [8];
  logic       load;

  int n_checks = 0;
  int n_fail   = 0;
  int dc, wn, sn;

  trinity_mutation_scheduler #(.ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .seq_enable    (seq_enable),
    .mutation_trit (mutation_trit),
    .mem_addr      (mem_addr),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mut_count     (mut_count),
    .gen_count     (gen_count)
  );

  always #5 clk = ~clk;

  // Weight RAM with one-cycle read latency, and a sequencer whose trit is looked up by address.
  always @(posedge clk) begin
    if (load)
      mem <= pre;
    else if (mem_we)
      mem[mem_addr] <= mem_wdata;
    if (mem_re)
      mem_rdata <= mem[mem_addr];
    if (seq_enable)
      mutation_trit <= tr[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_gen(input int l, input int max_cyc, output int done_cyc,
                         output int we_n, output int se_n);
    len   = l[AW:0];
    start = 1'b1;
    step();
    start    = 1'b0;
    done_cyc = -1;
    we_n     = 0;
    se_n     = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      if (!busy) break;
      if (mem_we) we_n++;
      if (seq_enable) se_n++;
      if (done && done_cyc < 0) done_cyc = k;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; len = '0; load = 1'b0;
    for (int i = 0; i < 8; i++) begin pre[i] = Z; tr[i] = Z; end
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_seq_enable", seq_enable, 0);
    chk("rst_strobes", {mem_re, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_mut_count", mut_count, 0);
    chk("rst_gen_count", gen_count, 0);

    // len 4: memory {P,N,Z,P}, trits {P,P,N,Z}
    pre[0] = P; pre[1] = N; pre[2] = Z; pre[3] = P;
    tr[0]  = P; tr[1]  = P; tr[2]  = N; tr[3]  = Z;
    preload();
    run_gen(4, 30, dc, wn, sn);
    chk("g1_done_cycle", dc, 9);
    chk("g1_writes", wn, 3);
    chk("g1_seq_pulses", sn, 4);
    chk("g1_mut_count", mut_count, 3);
    chk("g1_gen_count", gen_count, 1);
    chk("g1_mem0", mem[0], P);
    chk("g1_mem1", mem[1], Z);
    chk("g1_mem2", mem[2], N);
    chk("g1_mem3", mem[3], P);

    // len 0: straight to DONE without touching memory
    len = '0; start = 1'b1;
    step();
    start = 1'b0;
    chk("z_done", done, 1);
    chk("z_busy", busy, 1);
    chk("z_strobes", {seq_enable, mem_re, mem_we}, 0);
    step();
    chk("z_idle", {busy, done}, 0);
    chk("z_gen_count", gen_count, 2);

    // abort in APPLY of address 2 with a nonzero trit
    for (int i = 0; i < 8; i++) pre[i] = Z;
    tr[0] = P; tr[1] = N; tr[2] = P; tr[3] = P;
    preload();
    len = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("ab_pre_we", mem_we, 1);
    chk("ab_pre_addr", mem_addr, 2);
    chk("ab_pre_wdata", mem_wdata, P);
    abort = 1'b1;
    #1;
    chk("ab_we_suppressed", mem_we, 0);
    chk("ab_wdata_zero", mem_wdata, 0);
    step();
    abort = 1'b0;
    chk("ab_aborted_pulse", aborted, 1);
    chk("ab_idle", busy, 0);
    chk("ab_no_done", done, 0);
    step();
    chk("ab_aborted_clear", aborted, 0);
    chk("ab_gen_count", gen_count, 2);
    chk("ab_mut_count", mut_count, 2);
    chk("ab_mem0", mem[0], P);
    chk("ab_mem1", mem[1], N);
    chk("ab_mem2", mem[2], Z);

    // start+abort together in IDLE starts; a later start while busy is ignored
    tr[0] = P; tr[1] = P;
    preload();
    len = 4'd2; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 1);
    chk("sa_fetch", mem_re, 1);
    step();
    start = 1'b1; len = 4'd7;
    step();
    start = 1'b0; len = 4'd2;
    chk("sa_addr_kept", mem_addr, 1);
    dc = -1;
    for (int k = 3; k <= 20; k++) begin
      if (done && dc < 0) dc = k;
      if (!busy) break;
      step();
    end
    chk("sa_done_cycle", dc, 5);
    chk("sa_gen_count", gen_count, 3);
    chk("sa_mut_count", mut_count, 2);

    // memory word 11 with trit P writes P; trit 11 counts as Z
    pre[0] = X3; pre[1] = P;
    tr[0]  = P;  tr[1]  = X3;
    preload();
    run_gen(2, 20, dc, wn, sn);
    chk("x3_writes", wn, 1);
    chk("x3_mut_count", mut_count, 1);
    chk("x3_mem0", mem[0], P);
    chk("x3_mem1", mem[1], P);
    chk("x3_gen_count", gen_count, 4);

    // full-length generation with saturating P+P and N+N
    for (int i = 0; i < 8; i++) begin
      pre[i] = (i % 2 == 0) ? P : N;
      tr[i]  = (i % 2 == 0) ? P : N;
    end
    preload();
    run_gen(8, 40, dc, wn, sn);
    chk("full_done_cycle", dc, 17);
    chk("full_writes", wn, 8);
    chk("full_mut_count", mut_count, 8);
    chk("full_mem6", mem[6], P);
    chk("full_mem7", mem[7], N);
    chk("full_gen_count", gen_count, 5);

    // asynchronous reset mid-generation
    len = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_pulses", {done, aborted}, 0);
    chk("ar_strobes", {seq_enable, mem_re, mem_we}, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_gen_count", gen_count, 0);
    chk("ar_mut_count", mut_count, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_stays_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
